// File: rtl/p13_serial_tx_cell.sv
// Serial transmitter cell: shifts a WIDTH-bit word out MSB first on a divided sclk,
// then strobes latch so the receiver can load its output register.
module p13_serial_tx_cell #(
  parameter int WIDTH  = 8,
  parameter int CLKDIV = 4
) (
  input  logic             clk,
  input  logic             r,
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
  output logic             ready,
  output logic             sclk,
  output logic             sdo,
  output logic             latch,
  output logic             busy
);

  // Divider counts 0..CLKDIV-1 and the bit counter WIDTH-1..0, so neither can wrap.
  localparam int DIV_W = $clog2(CLKDIV + 1);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOW   = 2'd1,
    HIGH  = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] shift_r;
  logic [CNT_W-1:0] cnt_r;
  logic [DIV_W-1:0] div_r;
  logic             phase_end_s;

  assign phase_end_s = (div_r == DIV_LAST);

  // Frame sequencer: every output is a register updated alongside the state.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_r <= IDLE;
      shift_r <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      div_r   <= {DIV_W{1'b0}};
      ready   <= 1'b1;
      busy    <= 1'b0;
      sclk    <= 1'b0;
      sdo     <= 1'b0;
      latch   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (valid && ready) begin
            shift_r <= data;
            cnt_r   <= CNT_LOAD;
            div_r   <= {DIV_W{1'b0}};
            sdo     <= data[WIDTH-1];
            ready   <= 1'b0;
            busy    <= 1'b1;
            state_r <= LOW;
          end
        end
        LOW: begin
          if (phase_end_s) begin
            div_r   <= {DIV_W{1'b0}};
            sclk    <= 1'b1;
            state_r <= HIGH;
          end else begin
            div_r <= div_r + DIV_W'(1);
          end
        end
        HIGH: begin
          if (phase_end_s) begin
            div_r <= {DIV_W{1'b0}};
            sclk  <= 1'b0;
            if (cnt_r != {CNT_W{1'b0}}) begin
              // sdo moves only here, a full half-period ahead of the next sclk rise.
              cnt_r   <= cnt_r - CNT_W'(1);
              shift_r <= shift_r << 1;
              sdo     <= shift_r[WIDTH-2];
              state_r <= LOW;
            end else begin
              latch   <= 1'b1;
              state_r <= LATCH;
            end
          end else begin
            div_r <= div_r + DIV_W'(1);
          end
        end
        LATCH: begin
          if (phase_end_s) begin
            div_r   <= {DIV_W{1'b0}};
            latch   <= 1'b0;
            busy    <= 1'b0;
            ready   <= 1'b1;
            state_r <= IDLE;
          end else begin
            div_r <= div_r + DIV_W'(1);
          end
        end
        default: begin
          div_r   <= {DIV_W{1'b0}};
          ready   <= 1'b1;
          busy    <= 1'b0;
          sclk    <= 1'b0;
          latch   <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// Single D flip-flop with asynchronous active-high reset; building block for the
// serial-in/parallel-out receiver on the far side of the link.
module p13_dff_cell (
  input  logic clk,
  input  logic r,
  input  logic d,
  output logic q
);

  // Storage bit.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: tb/tb_p13_serial_tx_cell.sv
// Randomised self-checking bench for p13_serial_tx_cell with a p13_dff_cell loopback receiver.
module tb_p13_serial_tx_cell;

  logic       clk = 1'b0;
  logic       r;
  logic [7:0] data_a;
  logic       valid_a;
  logic [3:0] data_b;
  logic       valid_b;
  logic       ready_a, sclk_a, sdo_a, latch_a, busy_a;
  logic       ready_b, sclk_b, sdo_b, latch_b, busy_b;
  logic       sel;
  logic       ready_m, sclk_m, sdo_m, latch_m, busy_m;
  logic [7:0] rx_sh, rx_out;
  logic [8:0] rx_in;

  int n_checks = 0;
  int n_err    = 0;
  int tot_rises;
  int tot_latch;

  always #5 clk = ~clk;

  p13_serial_tx_cell #(.WIDTH(8), .CLKDIV(2)) dut_a (
    .clk(clk), .r(r), .data(data_a), .valid(valid_a), .ready(ready_a),
    .sclk(sclk_a), .sdo(sdo_a), .latch(latch_a), .busy(busy_a)
  );

  p13_serial_tx_cell #(.WIDTH(4), .CLKDIV(1)) dut_b (
    .clk(clk), .r(r), .data(data_b), .valid(valid_b), .ready(ready_b),
    .sclk(sclk_b), .sdo(sdo_b), .latch(latch_b), .busy(busy_b)
  );

  assign ready_m = sel ? ready_b : ready_a;
  assign sclk_m  = sel ? sclk_b  : sclk_a;
  assign sdo_m   = sel ? sdo_b   : sdo_a;
  assign latch_m = sel ? latch_b : latch_a;
  assign busy_m  = sel ? busy_b  : busy_a;

  // Receiver: shift chain clocked on sclk, output register loaded by latch.
  assign rx_in = {rx_sh, sdo_a};
  for (genvar i = 0; i < 8; i++) begin : g_rx
    p13_dff_cell u_sh  (.clk(sclk_a),  .r(r), .d(rx_in[i]), .q(rx_sh[i]));
    p13_dff_cell u_out (.clk(latch_a), .r(r), .d(rx_sh[i]), .q(rx_out[i]));
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One frame on the selected instance, starting and ending at a negedge.
  task automatic run_frame(input bit sel_b, input logic [7:0] w, input bit keep_valid,
                           input bit noise, input bit check_rx);
    int wd, dv, k, rises, lpulses, lhigh;
    logic prev_s, prev_l;
    logic [31:0] got_word, exp_word;
    wd       = sel_b ? 4 : 8;
    dv       = sel_b ? 1 : 2;
    sel      = sel_b;
    exp_word = sel_b ? {28'd0, w[3:0]} : {24'd0, w};
    chk("pre_ready", {31'd0, ready_m}, 32'd1);
    data_a = w;
    data_b = w[3:0];
    if (sel_b) valid_b = 1'b1; else valid_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("accept_busy", {31'd0, busy_m}, 32'd1);
    chk("accept_ready", {31'd0, ready_m}, 32'd0);
    chk("accept_sdo", {31'd0, sdo_m}, {31'd0, exp_word[wd-1]});
    if (!keep_valid) begin
      valid_a = 1'b0;
      valid_b = 1'b0;
    end
    k = 0; rises = 0; lpulses = 0; lhigh = 0;
    prev_s = 1'b0; prev_l = 1'b0; got_word = 32'd0;
    while (1) begin
      if (sclk_m && !prev_s) begin
        rises++;
        got_word = {got_word[30:0], sdo_m};
      end
      if (latch_m && !prev_l) lpulses++;
      if (latch_m) lhigh++;
      prev_s = sclk_m;
      prev_l = latch_m;
      if (ready_m || k >= 400) break;
      if (noise) begin
        data_a = 8'($urandom);
        data_b = 4'($urandom);
        if (sel_b) valid_b = 1'($urandom); else valid_a = 1'($urandom);
      end
      @(negedge clk);
      k++;
    end
    if (!keep_valid) begin
      valid_a = 1'b0;
      valid_b = 1'b0;
    end
    tot_rises += rises;
    tot_latch += lpulses;
    chk("frame_len", k, 2 * dv * wd + dv);
    chk("sclk_rises", rises, wd);
    chk("bits", got_word, exp_word);
    chk("latch_pulses", lpulses, 1);
    chk("latch_width", lhigh, dv);
    chk("idle_busy", {31'd0, busy_m}, 32'd0);
    chk("idle_sclk", {31'd0, sclk_m}, 32'd0);
    chk("idle_sdo", {31'd0, sdo_m}, {31'd0, exp_word[0]});
    if (check_rx) chk("rx_word", {24'd0, rx_out}, {24'd0, w});
  endtask

  task automatic reset_mid_frame();
    int rises, k;
    logic prev_s, bad;
    sel     = 1'b0;
    data_a  = 8'($urandom);
    valid_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_a = 1'b0;
    rises = 0; k = 0; prev_s = 1'b0;
    while (rises < 3 && k < 200) begin
      if (sclk_a && !prev_s) rises++;
      prev_s = sclk_a;
      if (rises < 3) begin
        @(negedge clk);
        k++;
      end
    end
    chk("rst_reach_3rd_rise", rises, 3);
    r = 1'b1;
    #1;
    chk("rst_sclk", {31'd0, sclk_a}, 32'd0);
    chk("rst_latch", {31'd0, latch_a}, 32'd0);
    chk("rst_ready", {31'd0, ready_a}, 32'd1);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_sdo", {31'd0, sdo_a}, 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (sclk_a || latch_a || sdo_a || !ready_a) bad = 1'b1;
    end
    chk("rst_held_quiet", {31'd0, bad}, 32'd0);
    r = 1'b0;
    run_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    r = 1'b1;
    sel = 1'b0;
    data_a = 8'd0; valid_a = 1'b0;
    data_b = 4'd0; valid_b = 1'b0;
    tot_rises = 0; tot_latch = 0;
    repeat (3) @(negedge clk);
    chk("reset_ready_a", {31'd0, ready_a}, 32'd1);
    chk("reset_busy_a", {31'd0, busy_a}, 32'd0);
    chk("reset_sclk_a", {31'd0, sclk_a}, 32'd0);
    chk("reset_sdo_a", {31'd0, sdo_a}, 32'd0);
    chk("reset_latch_a", {31'd0, latch_a}, 32'd0);
    chk("reset_ready_b", {31'd0, ready_b}, 32'd1);
    chk("reset_busy_b", {31'd0, busy_b}, 32'd0);
    r = 1'b0;

    run_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);

    tot_rises = 0; tot_latch = 0;
    run_frame(1'b0, 8'hFF, 1'b1, 1'b0, 1'b1);
    run_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("b2b_rises", tot_rises, 16);
    chk("b2b_latches", tot_latch, 2);

    for (int i = 0; i < 3; i++) run_frame(1'b0, 8'($urandom), 1'b0, 1'b1, 1'b1);

    reset_mid_frame();

    run_frame(1'b1, 8'h09, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) run_frame(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 256; i++)
      run_frame(1'b0, 8'($urandom), (i < 255) ? 1'($urandom) : 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
